// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired ALU instruction sequencer:
// opcode values, FSM state encoding, IR field positions and opcode classifiers.
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'd7;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'd9;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'd10;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'd11;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd15;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd16;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
    localparam logic [STATE_W-1:0] S_T0   = 4'd1;
    localparam logic [STATE_W-1:0] S_T1   = 4'd2;
    localparam logic [STATE_W-1:0] S_T2   = 4'd3;
    localparam logic [STATE_W-1:0] S_T3   = 4'd4;
    localparam logic [STATE_W-1:0] S_T4   = 4'd5;
    localparam logic [STATE_W-1:0] S_T5   = 4'd6;
    localparam logic [STATE_W-1:0] S_T6   = 4'd7;
    localparam logic [STATE_W-1:0] S_DONE = 4'd8;
    localparam logic [STATE_W-1:0] S_ERR  = 4'd9;

    // IR field positions: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
    localparam int IR_OPC_MSB = 31;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;

    // Opcodes the sequencer knows how to run; anything else traps to ERR in T3.
    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_ROL)) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // MUL/DIV produce a HI/LO pair and need the extra T6 write-back step.
    function automatic logic op_is_two_result(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Binary register-field to one-hot select decoder with enable.
// Output is all-zero when disabled, so several instances can be OR-ed onto one bus.
module reg_field_decoder #(
    parameter int REG_SEL_W = 4,
    parameter int NUM_REGS  = 16
) (
    input  logic                 i_en,
    input  logic [REG_SEL_W-1:0] i_sel,
    output logic [NUM_REGS-1:0]  o_onehot
);

    // One-hot decode of the selected register when enabled
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired control FSM for one register-register ALU instruction.
// Fetch T0-T2 (with memory wait states), operands/execute T3-T4,
// write-back T5 (and T6 for the HI half of MUL/DIV). All outputs are
// decoded from the state register and the (stable) IR contents.
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int REG_SEL_W    = 4,
    parameter int OPCODE_W     = 5,
    parameter int MEM_WAIT_MAX = 15,
    parameter int R0_ZERO      = 1
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Start,
    input  logic [31:0]         IR,
    input  logic                Mem_ready,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                ZHighIn,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                HIin,
    output logic                LOin,
    output logic [OPCODE_W-1:0] ALU_op,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

    logic [STATE_W-1:0]   r_state;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [STATE_W-1:0]   w_next_state;

    logic [OPCODE_W-1:0]  w_opcode;
    logic [REG_SEL_W-1:0] w_ra;
    logic [REG_SEL_W-1:0] w_rb;
    logic [REG_SEL_W-1:0] w_rc;
    logic                 w_legal;
    logic                 w_two;
    logic                 w_ra_en;
    logic [NUM_REGS-1:0]  w_ra_oh;
    logic [NUM_REGS-1:0]  w_rb_oh;
    logic [NUM_REGS-1:0]  w_rc_oh;
    logic                 w_unused_ir;

    assign w_opcode    = IR[IR_OPC_MSB -: OPCODE_W];
    assign w_ra        = IR[IR_RA_LSB +: REG_SEL_W];
    assign w_rb        = IR[IR_RB_LSB +: REG_SEL_W];
    assign w_rc        = IR[IR_RC_LSB +: REG_SEL_W];
    assign w_legal     = op_is_legal(w_opcode);
    assign w_two       = op_is_two_result(w_opcode);
    assign w_unused_ir = ^IR[IR_RC_LSB-1:0];

    // Ra load is suppressed for two-result ops (HI/LO take the result) and for R0 when hardwired zero
    assign w_ra_en = (r_state == S_T5) && !w_two && !((R0_ZERO != 0) && (w_ra == '0));

    reg_field_decoder #(.REG_SEL_W(REG_SEL_W), .NUM_REGS(NUM_REGS)) u_dec_ra (
        .i_en     (w_ra_en),
        .i_sel    (w_ra),
        .o_onehot (w_ra_oh)
    );

    reg_field_decoder #(.REG_SEL_W(REG_SEL_W), .NUM_REGS(NUM_REGS)) u_dec_rb (
        .i_en     ((r_state == S_T3) && w_legal),
        .i_sel    (w_rb),
        .o_onehot (w_rb_oh)
    );

    reg_field_decoder #(.REG_SEL_W(REG_SEL_W), .NUM_REGS(NUM_REGS)) u_dec_rc (
        .i_en     (r_state == S_T4),
        .i_sel    (w_rc),
        .o_onehot (w_rc_oh)
    );

    // State register and T1 wait counter; Clear aborts any instruction in flight
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_T0) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_T1) && !Mem_ready && (r_wait_cnt != CNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state sequencing through the fetch/execute/write-back steps
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (Start) w_next_state = S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1: begin
                if (Mem_ready)                   w_next_state = S_T2;
                else if (r_wait_cnt == CNT_MAX)  w_next_state = S_ERR;
            end
            S_T2:   w_next_state = S_T3;
            S_T3:   w_next_state = w_legal ? S_T4 : S_ERR;
            S_T4:   w_next_state = S_T5;
            S_T5:   w_next_state = w_two ? S_T6 : S_DONE;
            S_T6:   w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            S_ERR:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Moore strobe decode; at most one bus driver is active in any state
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ALU_op   = '0;
        case (r_state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: Yin = w_legal;
            S_T4: begin
                ALU_op  = w_opcode;
                ZLowIn  = 1'b1;
                ZHighIn = w_two;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin    = w_two;
            end
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy  = (r_state != S_IDLE);
    assign Done  = (r_state == S_DONE);
    assign Error = (r_state == S_ERR);
    assign Rout  = w_rb_oh | w_rc_oh;
    assign Rin   = w_ra_oh;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle expected output vectors
// are queued when an instruction is launched and compared as the DUT steps.
// A small bus/ALU/register-file model follows the strobes to check results.
module tb_alu_op_sequencer;

    localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4;
    localparam int P_T4 = 5, P_T5 = 6, P_T6 = 7, P_DONE = 8, P_ERR = 9;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] IR = '0;
    logic        Mem_ready = 1'b1;
    logic        Busy, Done, Error;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic        ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
    logic [4:0]  ALU_op;
    logic [15:0] Rout, Rin;

    logic [54:0] obs;
    logic [54:0] exp_v;
    logic [54:0] sb[$];
    int          n_vec = 0;
    int          n_bad = 0;

    logic [31:0] dp_r [16];
    logic [31:0] dp_y, dp_zlo, dp_bus;
    logic        dp_init = 1'b0;

    alu_op_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .IR(IR), .Mem_ready(Mem_ready),
        .Busy(Busy), .Done(Done), .Error(Error),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .HIin(HIin), .LOin(LOin), .ALU_op(ALU_op), .Rout(Rout), .Rin(Rin)
    );

    always #5 Clock = ~Clock;

    assign obs = {Busy, Done, Error, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
                  ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin, ALU_op, Rout, Rin};

    always_comb begin
        dp_bus = '0;
        if (Zlowout) dp_bus = dp_zlo;
        for (int i = 0; i < 16; i++) if (Rout[i]) dp_bus = dp_r[i];
    end

    always @(posedge Clock) begin
        if (dp_init) begin
            for (int i = 0; i < 16; i++) dp_r[i] <= '0;
            dp_r[2] <= 32'h12;
            dp_r[3] <= 32'h14;
        end else begin
            if (Yin) dp_y <= dp_bus;
            if (ZLowIn) begin
                case (ALU_op)
                    5'd3:    dp_zlo <= dp_y + dp_bus;
                    5'd4:    dp_zlo <= dp_y - dp_bus;
                    5'd5:    dp_zlo <= dp_y & dp_bus;
                    5'd6:    dp_zlo <= dp_y | dp_bus;
                    default: dp_zlo <= '0;
                endcase
            end
            for (int i = 0; i < 16; i++) if (Rin[i]) dp_r[i] <= dp_bus;
        end
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic logic [54:0] ev(input int ph, input logic [31:0] ir);
        logic [4:0]  op;
        logic        legal, two;
        logic        busy, done, err, pco, mar, inc, pci, rd, mdi, mdo, iri, yi;
        logic        zli, zhi, zlo, zho, hii, loi;
        logic [4:0]  aop;
        logic [15:0] ro, ri;
        op = ir[31:27];
        legal = ((op >= 5'd3) && (op <= 5'd11)) || (op == 5'd15) || (op == 5'd16);
        two = (op == 5'd15) || (op == 5'd16);
        {busy, done, err, pco, mar, inc, pci, rd, mdi, mdo, iri, yi} = '0;
        {zli, zhi, zlo, zho, hii, loi} = '0;
        aop = '0; ro = '0; ri = '0;
        busy = (ph != P_IDLE);
        done = (ph == P_DONE);
        err  = (ph == P_ERR);
        case (ph)
            P_T0: {pco, mar, inc, zli} = 4'hF;
            P_T1: {zlo, pci, rd, mdi} = 4'hF;
            P_T2: {mdo, iri} = 2'b11;
            P_T3: if (legal) begin ro = 16'd1 << ir[22:19]; yi = 1'b1; end
            P_T4: begin ro = 16'd1 << ir[18:15]; aop = op; zli = 1'b1; zhi = two; end
            P_T5: begin
                zlo = 1'b1;
                if (two) loi = 1'b1;
                else if (ir[26:23] != 4'd0) ri = 16'd1 << ir[26:23];
            end
            P_T6: {zho, hii} = 2'b11;
            default: ;
        endcase
        return {busy, done, err, pco, mar, inc, pci, rd, mdi, mdo, iri, yi,
                zli, zhi, zlo, zho, hii, loi, aop, ro, ri};
    endfunction

    task automatic push_instr(input logic [31:0] ir, input int waits, input int idle_n);
        logic [4:0] op;
        op = ir[31:27];
        sb.push_back(ev(P_T0, ir));
        if (waits >= 16) begin
            repeat (16) sb.push_back(ev(P_T1, ir));
            sb.push_back(ev(P_ERR, ir));
        end else begin
            repeat (waits + 1) sb.push_back(ev(P_T1, ir));
            sb.push_back(ev(P_T2, ir));
            sb.push_back(ev(P_T3, ir));
            if (!(((op >= 5'd3) && (op <= 5'd11)) || (op == 5'd15) || (op == 5'd16))) begin
                sb.push_back(ev(P_ERR, ir));
            end else begin
                sb.push_back(ev(P_T4, ir));
                sb.push_back(ev(P_T5, ir));
                if ((op == 5'd15) || (op == 5'd16)) sb.push_back(ev(P_T6, ir));
                sb.push_back(ev(P_DONE, ir));
            end
        end
        repeat (idle_n) sb.push_back(ev(P_IDLE, ir));
    endtask

    task automatic test_reset();
        Clear = 1'b0; Start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            n_vec++;
            if (obs !== 55'd0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %h want %h", k, obs, 55'd0);
            end
        end
        Clear = 1'b1; Start = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        n_vec++;
        if (obs !== 55'd0) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", obs, 55'd0);
        end
    endtask

    task automatic test_single_result();
        logic [31:0] irs [3];
        int          dst [3];
        logic [31:0] want [3];
        irs[0] = 32'h28918000; dst[0] = 1; want[0] = 32'h00000010;
        irs[1] = 32'h20918000; dst[1] = 1; want[1] = 32'hFFFFFFFE;
        irs[2] = mk_ir(5'd3, 4'd0, 4'd2, 4'd2); dst[2] = 0; want[2] = 32'h0;
        for (int t = 0; t < 3; t++) begin
            IR = irs[t];
            dp_init = 1'b1;
            @(posedge Clock); #1 dp_init = 1'b0;
            @(negedge Clock);
            push_instr(irs[t], 0, 2);
            Start = 1'b1;
            @(posedge Clock); #1 Start = 1'b0;
            while (sb.size() > 0) begin
                @(negedge Clock);
                exp_v = sb.pop_front();
                n_vec++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL single[%0d]: got %h want %h", t, obs, exp_v);
                end
                if (sb.size() > 0) @(posedge Clock);
            end
            n_vec++;
            if (dp_r[dst[t]] !== want[t]) begin
                n_bad++;
                $display("FAIL single_result[%0d] R%0d: got %h want %h", t, dst[t], dp_r[dst[t]], want[t]);
            end
        end
    endtask

    task automatic test_two_result();
        logic [31:0] irs [2];
        irs[0] = mk_ir(5'd15, 4'd0, 4'd3, 4'd4);
        irs[1] = mk_ir(5'd16, 4'd5, 4'd6, 4'd7);
        for (int t = 0; t < 2; t++) begin
            IR = irs[t];
            push_instr(irs[t], 0, 1);
            Start = 1'b1;
            @(posedge Clock); #1 Start = 1'b0;
            while (sb.size() > 0) begin
                @(negedge Clock);
                exp_v = sb.pop_front();
                n_vec++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL two_result[%0d]: got %h want %h", t, obs, exp_v);
                end
                if (sb.size() > 0) @(posedge Clock);
            end
        end
    endtask

    task automatic test_mem_wait();
        int waits [3];
        waits[0] = 3; waits[1] = 15; waits[2] = 16;
        IR = 32'h28918000;
        for (int t = 0; t < 3; t++) begin
            int k;
            push_instr(IR, waits[t], 2);
            Start = 1'b1;
            @(posedge Clock); #1 Start = 1'b0;
            k = 1;
            while (sb.size() > 0) begin
                Mem_ready = (k >= 2 && k < 2 + waits[t]) ? 1'b0 : 1'b1;
                @(negedge Clock);
                exp_v = sb.pop_front();
                n_vec++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL mem_wait[%0d] cyc%0d: got %h want %h", waits[t], k, obs, exp_v);
                end
                if (sb.size() > 0) begin
                    @(posedge Clock); #1;
                end
                k++;
            end
            Mem_ready = 1'b1;
        end
    endtask

    task automatic test_illegal();
        IR = mk_ir(5'd31, 4'd1, 4'd2, 4'd3);
        push_instr(IR, 0, 2);
        Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
        while (sb.size() > 0) begin
            @(negedge Clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL illegal: got %h want %h", obs, exp_v);
            end
            if (sb.size() > 0) @(posedge Clock);
        end
    endtask

    task automatic test_clear_mid();
        int k;
        IR = 32'h28918000;
        sb.push_back(ev(P_T0, IR));
        sb.push_back(ev(P_T1, IR));
        sb.push_back(ev(P_T2, IR));
        sb.push_back(ev(P_T3, IR));
        sb.push_back(ev(P_T4, IR));
        repeat (3) sb.push_back(ev(P_IDLE, IR));
        Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
        k = 1;
        while (sb.size() > 0) begin
            @(negedge Clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL clear_mid cyc%0d: got %h want %h", k, obs, exp_v);
            end
            if (k == 5) Clear = 1'b0;
            if (sb.size() > 0) begin
                @(posedge Clock); #1;
                Clear = 1'b1;
            end
            k++;
        end
    endtask

    task automatic test_start_busy();
        int k;
        IR = 32'h28918000;
        push_instr(IR, 0, 3);
        Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
        k = 1;
        while (sb.size() > 0) begin
            Start = (k == 3 || k == 5) ? 1'b1 : 1'b0;
            @(negedge Clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL start_busy cyc%0d: got %h want %h", k, obs, exp_v);
            end
            if (sb.size() > 0) begin
                @(posedge Clock); #1;
            end
            k++;
        end
        Start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge Clock);
        test_reset();
        test_single_result();
        test_two_result();
        test_mem_wait();
        test_illegal();
        test_clear_mid();
        test_start_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
